// File: rtl/core_regfile_pkg.sv
// Shared constants and types for the decode-stage register file controller.
package core_regfile_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = AW + 1;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_MEM = 1;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + CW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/reg_scoreboard_ctrl_if.sv
// Decode, writeback and register-file write-port signals of the scoreboard controller.
interface reg_scoreboard_ctrl_if;
  import core_regfile_pkg::*;

  logic          issue_req;
  reg_addr_t     src1_addr;
  reg_addr_t     src2_addr;
  reg_addr_t     dst_addr;
  logic          dst_valid;
  logic          stall_flag;

  logic          wb0_valid;
  reg_addr_t     wb0_addr;
  reg_data_t     wb0_data;
  logic          wb0_ready;

  logic          wb1_valid;
  reg_addr_t     wb1_addr;
  reg_data_t     wb1_data;
  logic          wb1_ready;

  logic          reg_wr;
  reg_addr_t     reg_wr_addr;
  reg_data_t     reg_wr_data;
  logic [AW:0]   pending_cnt;
  logic          wb_err;

  modport master (
    output issue_req, src1_addr, src2_addr, dst_addr, dst_valid,
    output wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    input  stall_flag, wb0_ready, wb1_ready,
    input  reg_wr, reg_wr_addr, reg_wr_data, pending_cnt, wb_err
  );

  modport slave (
    input  issue_req, src1_addr, src2_addr, dst_addr, dst_valid,
    input  wb0_valid, wb0_addr, wb0_data, wb1_valid, wb1_addr, wb1_data,
    output stall_flag, wb0_ready, wb1_ready,
    output reg_wr, reg_wr_addr, reg_wr_data, pending_cnt, wb_err
  );

endinterface

// File: rtl/wb_rr_arbiter2.sv
// Two-requester round-robin arbiter; last_q remembers the most recent winner.
module wb_rr_arbiter2
  import core_regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o_c
);

  logic last_q, last_d;

  // The requester that did not win last time takes a tie
  always_comb begin
    gnt_o_c = '0;
    last_d  = last_q;
    if (valid_i[WB_ALU] && (!valid_i[WB_MEM] || last_q == 1'(WB_MEM))) begin
      gnt_o_c[WB_ALU] = 1'b1;
      last_d          = 1'(WB_ALU);
    end else if (valid_i[WB_MEM]) begin
      gnt_o_c[WB_MEM] = 1'b1;
      last_d          = 1'(WB_MEM);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= 1'(WB_MEM);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/reg_scoreboard_ctrl.sv
// Register busy scoreboard with decode stall generation and a round-robin
// arbitrated, registered register-file write port.
module reg_scoreboard_ctrl
  import core_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  reg_scoreboard_ctrl_if.slave  bus
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_q, wr_d;
  reg_addr_t       wr_addr_q, wr_addr_d;
  reg_data_t       wr_data_q, wr_data_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      gnt;
  wb_req_t         sel;
  logic            stall;
  logic            issue_ok;

  wb_rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid_i ({bus.wb1_valid, bus.wb0_valid}),
    .gnt_o_c (gnt)
  );

  // RAW and WAW hazards both stall; no forwarding path exists
  always_comb begin
    stall    = bus.issue_req &
               (busy_q[bus.src1_addr] | busy_q[bus.src2_addr] |
                (bus.dst_valid & busy_q[bus.dst_addr]));
    issue_ok = bus.issue_req & ~stall;
  end

  always_comb begin
    sel       = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;

    if (gnt[WB_ALU]) begin
      sel.valid = 1'b1;
      sel.addr  = bus.wb0_addr;
      sel.data  = bus.wb0_data;
    end else if (gnt[WB_MEM]) begin
      sel.valid = 1'b1;
      sel.addr  = bus.wb1_addr;
      sel.data  = bus.wb1_data;
    end

    // Writebacks to r0 are granted but never reach the register file
    wr_d = sel.valid && (sel.addr != '0);
    if (wr_d) begin
      wr_addr_d = sel.addr;
      wr_data_d = sel.data;
    end
    err_d = err_q | (wr_d & ~busy_q[sel.addr]);

    // Clear first so a same-edge issue to the same register wins
    if (wr_q) busy_d[wr_addr_q] = 1'b0;
    if (issue_ok && bus.dst_valid && (bus.dst_addr != '0)) busy_d[bus.dst_addr] = 1'b1;

    cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.stall_flag  = stall;
  assign bus.wb0_ready   = gnt[WB_ALU];
  assign bus.wb1_ready   = gnt[WB_MEM];
  assign bus.reg_wr      = wr_q;
  assign bus.reg_wr_addr = wr_addr_q;
  assign bus.reg_wr_data = wr_data_q;
  assign bus.pending_cnt = cnt_q;
  assign bus.wb_err      = err_q;

endmodule

// File: doc/reg_scoreboard_ctrl.md
# reg_scoreboard_ctrl

Hazard and write-port controller for the decode-stage register file. It keeps a per-register busy scoreboard and raises `stall_flag` toward decode and the register file while a source or destination has a write in flight. It also arbitrates the register file's single write port between the ALU and memory writeback paths, driving `reg_wr`, `reg_wr_addr` and `reg_wr_data` as registered outputs.

## Interface
- `NREG`, 32: number of architectural registers.
- `AW`, 5: register address width, equal to log2(`NREG`).
- `DW`, 32: data width.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `issue_req`  in  1  decode presents an instruction this cycle.
- `src1_addr`, `src2_addr`  in  AW  source register addresses.
- `dst_addr`  in  AW  destination register address.
- `dst_valid`  in  1  instruction writes `dst_addr`.
- `stall_flag`  out  1  combinational; 1 = hold decode and hold the register file read outputs.
- `wb0_valid`, `wb0_addr`, `wb0_data`  in  1/AW/DW  ALU writeback request.
- `wb0_ready`  out  1  combinational grant to the ALU.
- `wb1_valid`, `wb1_addr`, `wb1_data`  in  1/AW/DW  memory writeback request.
- `wb1_ready`  out  1  combinational grant to memory.
- `reg_wr`, `reg_wr_addr`, `reg_wr_data`  out  1/AW/DW  registered register file write port.
- `pending_cnt`  out  AW+1  number of busy registers.
- `wb_err`  out  1  sticky; set on a writeback to a non-busy register.

## Operation
- **Scoreboard.** `busy[NREG]` holds one bit per register. Register 0 is never marked busy, and writebacks to register 0 are dropped: the grant is still given, `reg_wr` stays 0.
- **Stall condition.** `stall_flag = issue_req & (busy[src1_addr] | busy[src2_addr] | (dst_valid & busy[dst_addr]))`.
  - Read-after-write and write-after-write hazards both stall.
  - There is no forwarding.
- **Issue.** An issue is accepted when `issue_req & ~stall_flag`. If `dst_valid` is also set and `dst_addr != 0`, `busy[dst_addr]` is set at that edge.
- **Arbitration.** Two-way round-robin between wb0 and wb1.
  - Priority pointer `last` resets to wb1, so wb0 wins the first tie.
  - After any grant, the other requester has priority on the next tie.
  - A requester that is not granted holds `valid`, `addr` and `data` stable until `ready` is seen.
- **Write port.** On a grant, `reg_wr`, `reg_wr_addr` and `reg_wr_data` are registered at that edge and held for exactly one cycle. With no grant, `reg_wr` returns to 0.
- **Busy clear.** `busy[reg_wr_addr]` is cleared at the edge where `reg_wr = 1`. This is the same edge at which the register file performs the write.
- **Simultaneous set and clear.** If an issue sets the same register that is being cleared on the same edge, the set wins and the bit ends up 1. This can only happen after a stall-free issue following the clear, because of the write-after-write check.
- **Unexpected writeback.** A granted writeback whose address is not busy is still written. `wb_err` is set and stays set until reset.
- **`pending_cnt`.** Always equals the population count of `busy`. It is updated on the same edges as `busy`.
- **Reset.** Asserting `reset` at any time clears all state immediately. In-flight grants are discarded.

Reset values:
- `busy` = 0, `last` = wb1, `wb_err` = 0.
- `reg_wr` = 0, `reg_wr_addr` = 0, `reg_wr_data` = 0, `pending_cnt` = 0.
- `stall_flag`, `wb0_ready`, `wb1_ready` follow their combinational equations, so each is 0 when its request input is 0.

## Timing
Writeback latency:
- Cycle N: grant, with `wbX_valid` and `wbX_ready` both high.
- Cycle N+1: `reg_wr = 1`.
- Edge ending N+1: the register file writes and the busy bit clears.
- Cycle N+2: a stalled dependent instruction sees `stall_flag = 0` and reads the new value.
- Grant to stall release is therefore 2 cycles.

Issue-side timing:
- Issue accepted in cycle M: the busy bit is visible in M+1. A dependent instruction in M+1 stalls.
- `stall_flag` and both `ready` signals are purely combinational from current state and inputs, with no registered delay.

Throughput:
- The write port sustains one write per cycle.
- With both writeback requesters continuously valid, grants alternate wb0, wb1, wb0, …

## Structure
- Shared package `core_regfile_pkg` holds:
  - constants `NREG`, `AW`, `DW`;
  - requester index constants `WB_ALU = 0` and `WB_MEM = 1`.
- One sub-module, `wb_rr_arbiter2`: two-requester round-robin arbiter.
  - Inputs: valids, `clk`, `reset`.
  - Outputs: one-hot grant; it also holds the `last` pointer.
- Scoreboard, issue logic and write-port registers stay in the top level.

## Test plan
- **Reset.** Assert `reset = 0` mid-stream with `busy[5] = 1` and a pending grant → all outputs reach their reset values immediately; `pending_cnt = 0`.
- **Read-after-write.** Issue with dst 7, then src1 7 on the next cycle → `stall_flag = 1` until wb0 writes r7 = 0x55. `stall_flag` falls exactly 2 cycles after the grant; `reg_wr_addr = 7`, `reg_wr_data = 0x55`.
- **Tie.** wb0 and wb1 valid in the same cycle (r3 = 0xA, r4 = 0xB) → wb0 is granted first; `reg_wr` carries r3, then r4 on consecutive cycles; wb1 holds its request through the wait.
- **Register 0.** Issue with dst 0, then src 0 → no stall; a writeback to r0 is granted, `reg_wr` stays 0, `pending_cnt` is unchanged.
- **Unexpected writeback.** wb1 writes r9 while r9 is not busy → `reg_wr = 1` for r9 and `wb_err` is set and stays 1 until reset.
- **Write-after-write and re-issue.** With r12 busy, issue with dst 12 → stall. When r12's write occurs, an issue with dst 12 in the following cycle is accepted and `busy[12]` ends up 1.
